// File: rtl/mult_28_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mult_28_pipe
// Description : Three-stage pipelined 28x28 unsigned multiplier with a full
//               56-bit product, a valid bit and a sideband tag. It is built
//               from four registered 14x14 partial products. EN stalls every
//               stage in place.
//               Optional macro MULT_28_RANGE_CHECK_EN adds a sticky flag that
//               is raised by any accepted operand >= PRIME. Without the macro,
//               RANGE_ERR is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_28_pipe #(
    parameter int          LOGQ  = 28,
    parameter int unsigned PRIME = 32'h0FFF_0001,
    parameter int          TAGW  = 8
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                EN,
    input  logic                IN_VALID,
    input  logic [LOGQ-1:0]     A,
    input  logic [LOGQ-1:0]     B,
    input  logic [TAGW-1:0]     IN_TAG,
    output logic                OUT_VALID,
    output logic [2*LOGQ-1:0]   PROD,
    output logic [TAGW-1:0]     OUT_TAG,
    output logic                BUSY,
    output logic                RANGE_ERR
);

    localparam int c_half = LOGQ / 2;

    // The datapath split is only written for 28-bit operands and a modulus
    // that fits in them; reject anything else at elaboration.
    if (LOGQ != 28 || PRIME == 0 || PRIME >= (32'd1 << LOGQ)) begin : g_param_check
        $error("mult_28_pipe: unsupported LOGQ/PRIME");
    end

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic [LOGQ-1:0]   r_s1_a;
    logic [LOGQ-1:0]   r_s1_b;
    logic [TAGW-1:0]   r_s1_tag;

    // Capture operands; data loads whenever the pipe advances, valid or not.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_tag   <= '0;
        end else if (EN) begin
            r_s1_valid <= IN_VALID;
            r_s1_a     <= A;
            r_s1_b     <= B;
            r_s1_tag   <= IN_TAG;
        end
    end

    // 14-bit halves of the captured operands
    logic [c_half-1:0] w_ah, w_al, w_bh, w_bl;
    assign w_ah = r_s1_a[LOGQ-1:c_half];
    assign w_al = r_s1_a[c_half-1:0];
    assign w_bh = r_s1_b[LOGQ-1:c_half];
    assign w_bl = r_s1_b[c_half-1:0];

    // Partial products, each exactly 28 bits wide
    logic [LOGQ-1:0] w_pll, w_plh, w_phl, w_phh;
    assign w_pll = {{c_half{1'b0}}, w_al} * {{c_half{1'b0}}, w_bl};
    assign w_plh = {{c_half{1'b0}}, w_al} * {{c_half{1'b0}}, w_bh};
    assign w_phl = {{c_half{1'b0}}, w_ah} * {{c_half{1'b0}}, w_bl};
    assign w_phh = {{c_half{1'b0}}, w_ah} * {{c_half{1'b0}}, w_bh};

    // ------------------------------------------------------------------
    // Stage 2: registered partial products
    // ------------------------------------------------------------------
    logic              r_s2_valid;
    logic [LOGQ-1:0]   r_s2_pll, r_s2_plh, r_s2_phl, r_s2_phh;
    logic [TAGW-1:0]   r_s2_tag;

    // Register the four 14x14 products; tag and valid ride along.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_s2_valid <= 1'b0;
            r_s2_pll   <= '0;
            r_s2_plh   <= '0;
            r_s2_phl   <= '0;
            r_s2_phh   <= '0;
            r_s2_tag   <= '0;
        end else if (EN) begin
            r_s2_valid <= r_s1_valid;
            r_s2_pll   <= w_pll;
            r_s2_plh   <= w_plh;
            r_s2_phl   <= w_phl;
            r_s2_phh   <= w_phh;
            r_s2_tag   <= r_s1_tag;
        end
    end

    // Middle cross terms need 29 bits to hold their carry.
    logic [LOGQ:0]     w_mid;
    assign w_mid = {1'b0, r_s2_plh} + {1'b0, r_s2_phl};

    // The exact 57-bit sum always has a zero MSB, because the product of
    // two 28-bit values is below 2**56. Adding at 56 bits is therefore the
    // truncated result with no loss.
    logic [2*LOGQ-1:0] w_prod;
    assign w_prod = {{LOGQ{1'b0}}, r_s2_pll}
                  + {{(c_half-1){1'b0}}, w_mid, {c_half{1'b0}}}
                  + {r_s2_phh, {LOGQ{1'b0}}};

    // ------------------------------------------------------------------
    // Stage 3: final product register
    // ------------------------------------------------------------------
    logic              r_s3_valid;
    logic [2*LOGQ-1:0] r_s3_prod;
    logic [TAGW-1:0]   r_s3_tag;

    // Register the recombined product with its tag and valid.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_s3_valid <= 1'b0;
            r_s3_prod  <= '0;
            r_s3_tag   <= '0;
        end else if (EN) begin
            r_s3_valid <= r_s2_valid;
            r_s3_prod  <= w_prod;
            r_s3_tag   <= r_s2_tag;
        end
    end

    assign OUT_VALID = r_s3_valid;
    assign PROD      = r_s3_prod;
    assign OUT_TAG   = r_s3_tag;
    assign BUSY      = r_s1_valid | r_s2_valid | r_s3_valid;

    // ------------------------------------------------------------------
    // Optional operand range flag
    // ------------------------------------------------------------------
`ifdef MULT_28_RANGE_CHECK_EN
    localparam logic [LOGQ-1:0] c_prime = PRIME[LOGQ-1:0];

    logic r_range_err;

    // Sticky flag: set by any accepted operand at or above the modulus.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_range_err <= 1'b0;
        end else if (EN && IN_VALID && (A >= c_prime || B >= c_prime)) begin
            r_range_err <= 1'b1;
        end
    end

    assign RANGE_ERR = r_range_err;
`else
    assign RANGE_ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_28_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_28_pipe
// Description : Directed and streamed checks for mult_28_pipe against a
//               behavioural three-deep pipeline model and hand-computed
//               products.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_28_pipe;

    localparam int c_n = 1000;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        EN;
    logic        IN_VALID;
    logic [27:0] A;
    logic [27:0] B;
    logic [7:0]  IN_TAG;
    logic        OUT_VALID;
    logic [55:0] PROD;
    logic [7:0]  OUT_TAG;
    logic        BUSY;
    logic        RANGE_ERR;

    mult_28_pipe dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .EN        (EN),
        .IN_VALID  (IN_VALID),
        .A         (A),
        .B         (B),
        .IN_TAG    (IN_TAG),
        .OUT_VALID (OUT_VALID),
        .PROD      (PROD),
        .OUT_TAG   (OUT_TAG),
        .BUSY      (BUSY),
        .RANGE_ERR (RANGE_ERR)
    );

    always #5 CLK = ~CLK;

`ifdef MULT_28_RANGE_CHECK_EN
    localparam logic c_rerr_on = 1'b1;
`else
    localparam logic c_rerr_on = 1'b0;
`endif
    localparam logic [27:0] c_prime = 28'hFFF0001;

    int n_checks = 0;
    int n_errors = 0;
    int out_count;

    // Reference pipeline model
    logic        m_v [3];
    logic [55:0] m_p [3];
    logic [7:0]  m_t [3];
    logic        m_rerr;

    logic [27:0] a_arr [c_n];
    logic [27:0] b_arr [c_n];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0;
            m_p[i] = '0;
            m_t[i] = '0;
        end
        m_rerr = 1'b0;
    endtask

    // One clock: drive at negedge, update model at posedge, compare at next negedge.
    task automatic cycle(input logic en, input logic vld, input logic [27:0] a,
                         input logic [27:0] b, input logic [7:0] tag);
        EN = en; IN_VALID = vld; A = a; B = b; IN_TAG = tag;
        @(posedge CLK);
        if (en) begin
            m_v[2] = m_v[1]; m_p[2] = m_p[1]; m_t[2] = m_t[1];
            m_v[1] = m_v[0]; m_p[1] = m_p[0]; m_t[1] = m_t[0];
            m_v[0] = vld;
            m_p[0] = {28'd0, a} * {28'd0, b};
            m_t[0] = tag;
            if (c_rerr_on && vld && (a >= c_prime || b >= c_prime))
                m_rerr = 1'b1;
        end
        @(negedge CLK);
        check("out_valid", 64'(OUT_VALID), 64'(m_v[2]));
        check("busy", 64'(BUSY), 64'(m_v[0] | m_v[1] | m_v[2]));
        check("range_err", 64'(RANGE_ERR), 64'(m_rerr));
        if (m_v[2]) begin
            check("prod", 64'(PROD), 64'(m_p[2]));
            check("tag", 64'(OUT_TAG), 64'(m_t[2]));
        end
        if (en && OUT_VALID) out_count++;
    endtask

    // Single pair with a hand-computed product; checks the exact latency.
    task automatic directed(input string name, input logic [27:0] a, input logic [27:0] b,
                            input logic [7:0] tag, input logic [55:0] exp);
        cycle(1'b1, 1'b1, a, b, tag);
        check({name, "_lat1"}, 64'(OUT_VALID), 64'd0);
        check({name, "_busy1"}, 64'(BUSY), 64'd1);
        cycle(1'b1, 1'b0, 28'd0, 28'd0, 8'd0);
        check({name, "_lat2"}, 64'(OUT_VALID), 64'd0);
        check({name, "_busy2"}, 64'(BUSY), 64'd1);
        cycle(1'b1, 1'b0, 28'd0, 28'd0, 8'd0);
        check({name, "_valid"}, 64'(OUT_VALID), 64'd1);
        check({name, "_busy3"}, 64'(BUSY), 64'd1);
        check({name, "_prod"}, 64'(PROD), 64'(exp));
        check({name, "_tag"}, 64'(OUT_TAG), 64'(tag));
        cycle(1'b1, 1'b0, 28'd0, 28'd0, 8'd0);
        check({name, "_pulse"}, 64'(OUT_VALID), 64'd0);
        check({name, "_busy4"}, 64'(BUSY), 64'd0);
    endtask

    initial begin
        RSTN = 1'b0; EN = 1'b0; IN_VALID = 1'b0; A = '0; B = '0; IN_TAG = '0;
        model_reset();
        out_count = 0;
        for (int i = 0; i < c_n; i++) begin
            a_arr[i] = 28'($urandom);
            b_arr[i] = 28'($urandom);
        end
        a_arr[0] = 28'hFFFFFFF; b_arr[0] = 28'hFFFFFFF;
        a_arr[1] = 28'd0;       b_arr[1] = 28'h1234567;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_valid", 64'(OUT_VALID), 64'd0);
        check("rst_prod", 64'(PROD), 64'd0);
        check("rst_tag", 64'(OUT_TAG), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_rerr", 64'(RANGE_ERR), 64'd0);
        RSTN = 1'b1;
        @(negedge CLK);

        // Directed vectors
        directed("small", 28'd3, 28'd5, 8'h5A, 56'd15);
        directed("pm1sq", 28'hFFF0000, 28'hFFF0000, 8'h01, 56'hFFE00100000000);
        directed("maxsq", 28'hFFFFFFF, 28'hFFFFFFF, 8'h02, 56'hFFFFFFE0000001);
        directed("hilo", 28'h0004000, 28'h0000003, 8'h03, 56'h000000000C000);

        // Operand range flag, sticky through legal inputs
        directed("range", 28'hFFF0001, 28'd1, 8'h11, 56'h0000000FFF0001);
        check("rerr_set", 64'(RANGE_ERR), 64'(c_rerr_on));
        directed("legal", 28'd2, 28'd3, 8'h12, 56'd6);
        check("rerr_sticky", 64'(RANGE_ERR), 64'(c_rerr_on));

        // Continuous stream
        out_count = 0;
        for (int i = 0; i < c_n; i++)
            cycle(1'b1, 1'b1, a_arr[i], b_arr[i], 8'(i));
        repeat (3) cycle(1'b1, 1'b0, 28'd0, 28'd0, 8'd0);
        check("stream_count", 64'(out_count), 64'(c_n));

        // Same stream with random stalls; upstream holds the pair while EN=0
        begin
            int idx;
            int guard;
            idx = 0;
            guard = 0;
            out_count = 0;
            while (idx < c_n && guard < 20 * c_n) begin
                logic en;
                en = ($urandom_range(0, 99) >= 30);
                cycle(en, 1'b1, a_arr[idx], b_arr[idx], 8'(idx));
                if (en) idx++;
                guard++;
            end
            check("stall_progress", 64'(idx), 64'(c_n));
        end
        repeat (3) cycle(1'b1, 1'b0, 28'd0, 28'd0, 8'd0);
        check("stall_count", 64'(out_count), 64'(c_n));

        // Asynchronous reset with pairs in flight
        cycle(1'b1, 1'b1, 28'h1234, 28'h10, 8'h21);
        cycle(1'b1, 1'b1, 28'h5, 28'h7, 8'h22);
        cycle(1'b1, 1'b1, 28'h9, 28'h9, 8'h23);
        check("pre_rst_prod", 64'(PROD), 64'h12340);
        EN = 1'b0;
        #2;
        RSTN = 1'b0;
        #1;
        check("arst_valid", 64'(OUT_VALID), 64'd0);
        check("arst_busy", 64'(BUSY), 64'd0);
        check("arst_prod", 64'(PROD), 64'd0);
        check("arst_tag", 64'(OUT_TAG), 64'd0);
        check("arst_rerr", 64'(RANGE_ERR), 64'd0);
        model_reset();
        @(negedge CLK);
        RSTN = 1'b1;

        // First pair after release, no stale results
        directed("post_rst", 28'd7, 28'd9, 8'h77, 56'd63);
        repeat (3) cycle(1'b1, 1'b0, 28'd0, 28'd0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
